// File: rtl/click_rr_arbiter.sv
// click_rr_arbiter: round-robin merge of N_REQ two-phase click channels onto one tagged downstream channel.
// Define CLICK_ARB_SYNC_EN to pass in_req and out_ack through 2-flop synchronizers.
module click_rr_arbiter #(
    parameter  int N_REQ      = 4,
    parameter  int DATA_WIDTH = 7,
    localparam int ID_W       = $clog2(N_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                in_req,
    input  logic [N_REQ*(DATA_WIDTH+1)-1:0] in_data,
    output logic [N_REQ-1:0]                in_ack,
    output logic                            out_req,
    output logic [DATA_WIDTH:0]             out_data,
    output logic [ID_W-1:0]                 out_id,
    input  logic                            out_ack
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t              state_q;
    logic [N_REQ-1:0]    in_ack_q;
    logic [N_REQ-1:0]    req_v;
    logic [N_REQ-1:0]    pending;
    logic                out_req_q;
    logic                ack_v;
    logic [DATA_WIDTH:0] out_data_q;
    logic [ID_W-1:0]     out_id_q;
    logic [ID_W-1:0]     last_q;
    logic [ID_W-1:0]     sel_d;
`ifdef CLICK_ARB_SYNC_EN
    logic [N_REQ-1:0] req_s1_q;
    logic [N_REQ-1:0] req_s2_q;
    logic             ack_s1_q;
    logic             ack_s2_q;
    // two-flop synchronizers bring producer and consumer phases into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_s1_q <= '0;
            req_s2_q <= '0;
            ack_s1_q <= 1'b0;
            ack_s2_q <= 1'b0;
        end else begin
            req_s1_q <= in_req;
            req_s2_q <= req_s1_q;
            ack_s1_q <= out_ack;
            ack_s2_q <= ack_s1_q;
        end
    end
    assign req_v = req_s2_q;
    assign ack_v = ack_s2_q;
`else
    assign req_v = in_req;
    assign ack_v = out_ack;
`endif
    assign pending = req_v ^ in_ack_q;
    // rotating priority: scan farthest to nearest so the first pending index after last_q wins
    always_comb begin
        sel_d = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (pending[(int'(last_q) + i) % N_REQ]) sel_d = ID_W'((int'(last_q) + i) % N_REQ);
        end
    end
    // IDLE grants and launches one word; BUSY waits for the downstream phase match, then acks the source
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ack_q   <= '0;
            out_req_q  <= 1'b0;
            out_data_q <= '0;
            out_id_q   <= '0;
            last_q     <= ID_W'(N_REQ - 1);
        end else if (state_q == IDLE) begin
            if (|pending) begin
                out_data_q <= in_data[int'(sel_d) * (DATA_WIDTH + 1) +: DATA_WIDTH + 1];
                out_id_q   <= sel_d;
                out_req_q  <= ~out_req_q;
                state_q    <= BUSY;
            end
        end else if (ack_v == out_req_q) begin
            in_ack_q[out_id_q] <= ~in_ack_q[out_id_q];
            last_q             <= out_id_q;
            state_q            <= IDLE;
        end
    end
    assign in_ack   = in_ack_q;
    assign out_req  = out_req_q;
    assign out_data = out_data_q;
    assign out_id   = out_id_q;
endmodule
